riego_multicanal: RTL and testbench

//  Parametrised irrigation scheduler; generalises the single-threshold pump trigger to N channels.

---
 rtl/riego_multicanal_if.sv | 32 +++
 rtl/riego_multicanal.sv | 181 ++++++++++++++++++
 tb/tb_riego_multicanal.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riego_multicanal_if.sv
// Signal bundle between the humidity decoder / control side and the multichannel irrigation scheduler.
// hum_valid is a one-cycle strobe with no ready: the scheduler accepts every sample in the cycle it is valid.
interface riego_multicanal_if #(
  parameter int N_CH  = 4,
  parameter int HUM_W = 12
);
  localparam int CW = $clog2(N_CH);

  logic                   en;
  logic                   hum_valid;
  logic [CW-1:0]          hum_ch;
  logic [HUM_W-1:0]       humedad;
  logic [N_CH*HUM_W-1:0]  umbrales;
  logic [N_CH-1:0]        mod_presente;
  logic [N_CH-1:0]        alarma_clr;
  logic [N_CH-1:0]        bomba;
  logic                   regar_any;
  logic [N_CH-1:0]        alarma;
  logic [CW-1:0]          ch_activo;
  logic [1:0]             dbg_state;
  logic [N_CH-1:0]        dbg_need;

  modport master (
    output en, hum_valid, hum_ch, humedad, umbrales, mod_presente, alarma_clr,
    input  bomba, regar_any, alarma, ch_activo, dbg_state, dbg_need
  );

  modport slave (
    input  en, hum_valid, hum_ch, humedad, umbrales, mod_presente, alarma_clr,
    output bomba, regar_any, alarma, ch_activo, dbg_state, dbg_need
  );
endinterface

// File: rtl/riego_multicanal.sv
// N-channel irrigation scheduler: per-channel need flags with hysteresis, round-robin single pump grant,
// watering timeout with sticky alarm and a fixed pause after every grant.
module riego_multicanal #(
  parameter int N_CH        = 4,
  parameter int HUM_W       = 12,
  parameter int HIST        = 64,
  parameter int TICK_DIV    = 50000000,
  parameter int MAX_RIEGO_S = 30,
  parameter int MIN_PAUSA_S = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  riego_multicanal_if.slave bus
);
  localparam int CW   = $clog2(N_CH);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SMAX = (MAX_RIEGO_S > MIN_PAUSA_S) ? MAX_RIEGO_S : MIN_PAUSA_S;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int HW1  = HUM_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SELECT  = 2'd1,
    S_REGANDO = 2'd2,
    S_PAUSA   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_activo_q, ch_activo_d;
  logic [N_CH-1:0] need_q, need_d;
  logic [N_CH-1:0] alarma_q, alarma_d;
  logic [N_CH-1:0] bomba_q, bomba_d;
  logic            regar_any_q, regar_any_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   seg_q, seg_d;

  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] alarm_set;
  logic [CW-1:0]   pick;
  logic            found;
  logic            hum_ok;
  logic            tick_s;
  logic            timeout;
  logic            pause_done;
  logic [HUM_W-1:0] clr_thr [N_CH];

  // Clear level is threshold + HIST, saturated to the largest representable sample.
  for (genvar g = 0; g < N_CH; g++) begin : g_thr
    logic [HW1-1:0] sum;
    assign sum        = {1'b0, bus.umbrales[g*HUM_W +: HUM_W]} + HW1'(HIST);
    assign clr_thr[g] = sum[HUM_W] ? {HUM_W{1'b1}} : sum[HUM_W-1:0];
  end

  assign hum_ok = (int'(bus.hum_ch) < N_CH);

  always_comb begin
    need_d = need_q;
    if (bus.hum_valid && hum_ok) begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.hum_ch == CW'(i)) begin
          if (bus.humedad < bus.umbrales[i*HUM_W +: HUM_W]) begin
            need_d[i] = 1'b1;
          end else if (bus.humedad >= clr_thr[i]) begin
            need_d[i] = 1'b0;
          end
        end
      end
    end
  end

  assign elig = need_q & bus.mod_presente & ~alarma_q;

  // Search starts just after the last granted channel, so the last granted one is tried last.
  always_comb begin
    logic [CW-1:0] idx;
    pick  = ch_activo_q;
    found = 1'b0;
    idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = CW'((int'(ch_activo_q) + k) % N_CH);
      if (elig[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign tick_s     = (presc_q == PW'(TICK_DIV - 1));
  assign timeout    = (state_q == S_REGANDO) && tick_s && (seg_q == SW'(MAX_RIEGO_S - 1));
  assign pause_done = (state_q == S_PAUSA) && tick_s && (seg_q == SW'(MIN_PAUSA_S - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_activo_q <= CW'(N_CH - 1);
      need_q      <= '0;
      alarma_q    <= '0;
      bomba_q     <= '0;
      regar_any_q <= 1'b0;
      presc_q     <= '0;
      seg_q       <= '0;
    end else begin
      state_q     <= state_d;
      ch_activo_q <= ch_activo_d;
      need_q      <= need_d;
      alarma_q    <= alarma_d;
      bomba_q     <= bomba_d;
      regar_any_q <= regar_any_d;
      presc_q     <= presc_d;
      seg_q       <= seg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_activo_d = ch_activo_q;
    alarm_set   = '0;
    if (!bus.en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|elig) state_d = S_SELECT;
        end
        S_SELECT: begin
          if (found) begin
            ch_activo_d = pick;
            state_d     = S_REGANDO;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REGANDO: begin
          if (!need_q[ch_activo_q] || !bus.mod_presente[ch_activo_q] || timeout) begin
            state_d = S_PAUSA;
          end
          // A need cleared before or at the timeout edge means the plant was served: no alarm.
          if (timeout && need_q[ch_activo_q] && need_d[ch_activo_q] && bus.mod_presente[ch_activo_q]) begin
            alarm_set[ch_activo_q] = 1'b1;
          end
        end
        S_PAUSA: begin
          if (pause_done) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign alarma_d = (alarma_q & ~bus.alarma_clr) | alarm_set;

  always_comb begin
    presc_d = presc_q;
    seg_d   = seg_q;
    if ((state_d != state_q) || !((state_q == S_REGANDO) || (state_q == S_PAUSA))) begin
      presc_d = '0;
      seg_d   = '0;
    end else if (tick_s) begin
      presc_d = '0;
      if (seg_q != SW'(SMAX)) seg_d = seg_q + SW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_comb begin
    bomba_d     = '0;
    regar_any_d = 1'b0;
    if (state_d == S_REGANDO) begin
      bomba_d     = {{(N_CH-1){1'b0}}, 1'b1} << ch_activo_d;
      regar_any_d = 1'b1;
    end
  end

  assign bus.bomba     = bomba_q;
  assign bus.regar_any = regar_any_q;
  assign bus.alarma    = alarma_q;
  assign bus.ch_activo = ch_activo_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_need  = need_q;
endmodule

// File: tb/tb_riego_multicanal.sv
// Self-checking bench for riego_multicanal: hand-written grant/timeout/enable/reset sequences,
// then a table of hysteresis vectors, with expected values queued and compared as outputs appear.
module tb_riego_multicanal;
  localparam int N_CH  = 4;
  localparam int HUM_W = 12;
  localparam int CW    = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_PAUSA = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int         ch;
    int         umb;
    int         hum;
    logic [3:0] need;
  } vec_t;
  vec_t vecs[14];

  riego_multicanal_if #(.N_CH(N_CH), .HUM_W(HUM_W)) bus();

  riego_multicanal #(
    .N_CH(N_CH), .HUM_W(HUM_W), .HIST(64), .TICK_DIV(10), .MAX_RIEGO_S(5), .MIN_PAUSA_S(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act);
    logic [15:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: got %0h, nothing expected in queue", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_errors++;
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    expect_v(exp);
    check(name, act);
  endtask

  task automatic send(input int ch, input int val);
    bus.hum_valid = 1'b1;
    bus.hum_ch    = CW'(ch);
    bus.humedad   = HUM_W'(val);
    tick();
    bus.hum_valid = 1'b0;
  endtask

  task automatic set_umb(input int ch, input int v);
    bus.umbrales[ch*HUM_W +: HUM_W] = HUM_W'(v);
  endtask

  task automatic count_on(input string name, input logic [3:0] pat, input int exp_len);
    int cnt = 0;
    expect_v(16'(exp_len));
    while (bus.bomba == pat && cnt < 200) begin
      cnt++;
      tick();
    end
    check(name, 16'(cnt));
  endtask

  task automatic wait_state(input string name, input logic [1:0] st, input int bound);
    int n = 0;
    while (bus.dbg_state != st && n < bound) begin
      n++;
      tick();
    end
    chk(name, 16'(bus.dbg_state), 16'(st));
  endtask

  initial begin
    vecs[0]  = '{0, 1000,  999, 4'b0001};
    vecs[1]  = '{0, 1000, 1000, 4'b0001};
    vecs[2]  = '{0, 1000, 1063, 4'b0001};
    vecs[3]  = '{0, 1000, 1064, 4'b0000};
    vecs[4]  = '{1,  500,    0, 4'b0010};
    vecs[5]  = '{2, 4090, 4094, 4'b0010};
    vecs[6]  = '{2, 4090, 4089, 4'b0110};
    vecs[7]  = '{2, 4090, 4094, 4'b0110};
    vecs[8]  = '{2, 4090, 4095, 4'b0010};
    vecs[9]  = '{3,    0,    0, 4'b0010};
    vecs[10] = '{3, 4095, 4094, 4'b1010};
    vecs[11] = '{3, 4095, 4095, 4'b0010};
    vecs[12] = '{1,  500,  563, 4'b0010};
    vecs[13] = '{1,  500,  564, 4'b0000};

    rst_n            = 1'b0;
    bus.en           = 1'b0;
    bus.hum_valid    = 1'b0;
    bus.hum_ch       = '0;
    bus.humedad      = '0;
    bus.umbrales     = '0;
    bus.mod_presente = 4'b1111;
    bus.alarma_clr   = '0;
    tick();
    tick();
    chk("reset_bomba",     16'(bus.bomba),     16'h0);
    chk("reset_regar_any", 16'(bus.regar_any), 16'h0);
    chk("reset_alarma",    16'(bus.alarma),    16'h0);
    chk("reset_ch_activo", 16'(bus.ch_activo), 16'h3);
    chk("reset_state",     16'(bus.dbg_state), 16'(ST_IDLE));
    chk("reset_need",      16'(bus.dbg_need),  16'h0);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    tick();

    // Basic grant, hysteresis hold, clear and pause length on ch0.
    set_umb(0, 1000);
    expect_v(16'h0); expect_v(16'h0); expect_v(16'h1);
    send(0, 900);
    check("t1_bomba_e0", 16'(bus.bomba));
    tick();
    check("t1_bomba_e1", 16'(bus.bomba));
    tick();
    check("t1_bomba_e2", 16'(bus.bomba));
    chk("t1_regar_any", 16'(bus.regar_any), 16'h1);
    chk("t1_ch_activo", 16'(bus.ch_activo), 16'h0);
    send(0, 1050);
    chk("t1_hold_1050", 16'(bus.bomba), 16'h1);
    send(0, 1064);
    chk("t1_clear_edge", 16'(bus.bomba), 16'h1);
    tick();
    chk("t1_off_after_clear", 16'(bus.bomba), 16'h0);
    chk("t1_regar_off", 16'(bus.regar_any), 16'h0);
    repeat (19) tick();
    chk("t1_pause_19", 16'(bus.dbg_state), 16'(ST_PAUSA));
    tick();
    chk("t1_pause_20_idle", 16'(bus.dbg_state), 16'(ST_IDLE));

    // Round-robin: ch1 and ch3 both need, last grant was ch0.
    set_umb(1, 2000);
    set_umb(3, 2000);
    send(1, 100);
    send(3, 100);
    tick();
    chk("t2_first_ch1", 16'(bus.bomba), 16'h2);
    send(1, 2064);
    tick();
    chk("t2_ch1_off", 16'(bus.bomba), 16'h0);
    repeat (20) tick();
    chk("t2_pause_done", 16'(bus.dbg_state), 16'(ST_IDLE));
    tick();
    chk("t2_select", 16'(bus.bomba), 16'h0);
    tick();
    chk("t2_then_ch3", 16'(bus.bomba), 16'h8);
    chk("t2_ch_activo3", 16'(bus.ch_activo), 16'h3);
    send(3, 2064);
    tick();
    chk("t2_ch3_off", 16'(bus.bomba), 16'h0);
    wait_state("t2_idle", ST_IDLE, 40);

    // Timeout on ch2, sticky alarm, regrant only after clear, set wins over held clear.
    set_umb(2, 1500);
    send(2, 100);
    tick();
    tick();
    chk("t3_grant_ch2", 16'(bus.bomba), 16'h4);
    count_on("t3_on_cycles", 4'b0100, 50);
    chk("t3_alarma", 16'(bus.alarma), 16'h4);
    wait_state("t3_pause_idle", ST_IDLE, 40);
    repeat (5) tick();
    chk("t3_no_regrant", 16'(bus.bomba), 16'h0);
    chk("t3_still_idle", 16'(bus.dbg_state), 16'(ST_IDLE));
    bus.alarma_clr = 4'b0100;
    tick();
    bus.alarma_clr = 4'b0000;
    chk("t3_alarm_cleared", 16'(bus.alarma), 16'h0);
    tick();
    chk("t3_select", 16'(bus.dbg_state), 16'(ST_SEL));
    tick();
    chk("t3_regrant_ch2", 16'(bus.bomba), 16'h4);
    bus.alarma_clr = 4'b0100;
    count_on("t3_on_cycles_2", 4'b0100, 50);
    chk("t3_set_beats_clr", 16'(bus.alarma), 16'h4);
    send(2, 1564);
    bus.alarma_clr = 4'b0000;
    chk("t3_clr_next", 16'(bus.alarma), 16'h0);
    wait_state("t3_idle2", ST_IDLE, 40);
    repeat (3) tick();
    chk("t3_quiet", 16'(bus.bomba), 16'h0);

    // Enable drop mid-watering and recovery.
    send(0, 900);
    tick();
    tick();
    chk("t4_grant_ch0", 16'(bus.bomba), 16'h1);
    repeat (10) tick();
    bus.en = 1'b0;
    tick();
    chk("t4_en_off_bomba", 16'(bus.bomba), 16'h0);
    chk("t4_en_off_alarma", 16'(bus.alarma), 16'h0);
    chk("t4_en_off_idle", 16'(bus.dbg_state), 16'(ST_IDLE));
    repeat (3) tick();
    bus.en = 1'b1;
    tick();
    chk("t4_regrant_e1", 16'(bus.bomba), 16'h0);
    tick();
    chk("t4_regrant_e2", 16'(bus.bomba), 16'h1);

    // Module removed while watering.
    bus.mod_presente = 4'b1110;
    tick();
    chk("t5_mod_off_bomba", 16'(bus.bomba), 16'h0);
    chk("t5_mod_off_alarma", 16'(bus.alarma), 16'h0);
    chk("t5_mod_off_pausa", 16'(bus.dbg_state), 16'(ST_PAUSA));
    send(0, 1064);
    bus.mod_presente = 4'b1111;
    wait_state("t5_idle", ST_IDLE, 40);
    repeat (3) tick();
    chk("t5_quiet", 16'(bus.bomba), 16'h0);

    // Asynchronous reset while watering, with an alarm pending.
    send(1, 100);
    tick();
    tick();
    chk("t6_grant_ch1", 16'(bus.bomba), 16'h2);
    count_on("t6_on_cycles", 4'b0010, 50);
    chk("t6_alarma", 16'(bus.alarma), 16'h2);
    wait_state("t6_idle", ST_IDLE, 40);
    send(0, 900);
    tick();
    tick();
    chk("t6_grant_ch0", 16'(bus.bomba), 16'h1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bomba",     16'(bus.bomba),     16'h0);
    chk("t6_rst_regar",     16'(bus.regar_any), 16'h0);
    chk("t6_rst_alarma",    16'(bus.alarma),    16'h0);
    chk("t6_rst_ch_activo", 16'(bus.ch_activo), 16'h3);
    chk("t6_rst_need",      16'(bus.dbg_need),  16'h0);
    tick();
    rst_n  = 1'b1;
    bus.en = 1'b0;
    tick();

    // Hysteresis table, scheduler disabled so only the need flags move.
    for (int i = 0; i < 14; i++) begin
      set_umb(vecs[i].ch, vecs[i].umb);
      expect_v(16'(vecs[i].need));
      send(vecs[i].ch, vecs[i].hum);
      check($sformatf("vec%0d_need", i), 16'(bus.dbg_need));
    end
    chk("vec_bomba_off", 16'(bus.bomba), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
